tile_update_scheduler: RTL and testbench



---
 rtl/tile_update_scheduler.sv | 151 +++++++++++++++
 tb/tb_tile_update_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_update_scheduler.sv
// Scans the tile map in row-major order and issues draw commands for tiles whose
// object code differs from the shadow copy, or for every tile on a full redraw.
module tile_update_scheduler #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int CODE_W = 3,
    parameter int XY_W   = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              start_frame,
    input  logic              force_redraw,
    input  logic [CODE_W-1:0] obj_code_in,
    input  logic              cmd_done,
    output logic [XY_W-1:0]   x,
    output logic [XY_W-1:0]   y,
    output logic              cmd_valid,
    output logic [XY_W-1:0]   cmd_x,
    output logic [XY_W-1:0]   cmd_y,
    output logic [CODE_W-1:0] cmd_code,
    output logic              busy,
    output logic              init_cycle,
    output logic              frame_done
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int          IDX_W = $clog2(CELLS);
    localparam logic [XY_W-1:0] X_LAST = XY_W'(GRID_W - 1);
    localparam logic [XY_W-1:0] Y_LAST = XY_W'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [CODE_W-1:0] shadow [CELLS];
    logic [XY_W-1:0]   x_n, y_n, cmd_x_n, cmd_y_n;
    logic [CODE_W-1:0] cmd_code_n;
    logic              cmd_valid_n, init_cycle_n;
    logic              redraw_pend, redraw_pend_n, redraw_pass, redraw_pass_n;
    logic              start_pending, start_pending_n;
    logic              advance, shadow_we;
    logic [IDX_W-1:0]  scan_idx, cmd_idx;

    function automatic logic [IDX_W-1:0] flat(input logic [XY_W-1:0] col, input logic [XY_W-1:0] row);
        return IDX_W'(row) * IDX_W'(GRID_W) + IDX_W'(col);
    endfunction

    assign scan_idx   = flat(x, y);
    assign cmd_idx    = flat(cmd_x, cmd_y);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_n         = state;
        x_n             = x;
        y_n             = y;
        cmd_x_n         = cmd_x;
        cmd_y_n         = cmd_y;
        cmd_code_n      = cmd_code;
        cmd_valid_n     = cmd_valid;
        init_cycle_n    = init_cycle;
        redraw_pass_n   = redraw_pass;
        redraw_pend_n   = redraw_pend | force_redraw;
        start_pending_n = start_pending | start_frame;
        advance         = 1'b0;
        shadow_we       = 1'b0;

        case (state)
            IDLE: begin
                if (start_pending || start_frame) begin
                    state_n         = SCAN;
                    x_n             = '0;
                    y_n             = '0;
                    start_pending_n = 1'b0;
                    // The pending flag moves into the per-pass copy; a force arriving
                    // mid-pass re-arms pending so the next pass is full as well.
                    redraw_pass_n   = redraw_pend | force_redraw;
                    redraw_pend_n   = 1'b0;
                end
            end
            SCAN: begin
                if (redraw_pass || redraw_pend || (obj_code_in != shadow[scan_idx])) begin
                    cmd_x_n     = x;
                    cmd_y_n     = y;
                    cmd_code_n  = obj_code_in;
                    cmd_valid_n = 1'b1;
                    state_n     = WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (cmd_done) begin
                    cmd_valid_n = 1'b0;
                    shadow_we   = 1'b1;
                    advance     = 1'b1;
                end
            end
            DONE: begin
                state_n       = IDLE;
                x_n           = '0;
                y_n           = '0;
                redraw_pass_n = 1'b0;
                init_cycle_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (x == X_LAST && y == Y_LAST) begin
                state_n = DONE;
            end else begin
                state_n = SCAN;
                if (x == X_LAST) begin
                    x_n = '0;
                    y_n = y + 1'b1;
                end else begin
                    x_n = x + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            cmd_x         <= '0;
            cmd_y         <= '0;
            cmd_code      <= '0;
            cmd_valid     <= 1'b0;
            init_cycle    <= 1'b1;
            redraw_pend   <= 1'b1;
            redraw_pass   <= 1'b0;
            start_pending <= 1'b1;
            for (int unsigned i = 0; i < CELLS; i++) shadow[i] <= '0;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            cmd_x         <= cmd_x_n;
            cmd_y         <= cmd_y_n;
            cmd_code      <= cmd_code_n;
            cmd_valid     <= cmd_valid_n;
            init_cycle    <= init_cycle_n;
            redraw_pend   <= redraw_pend_n;
            redraw_pass   <= redraw_pass_n;
            start_pending <= start_pending_n;
            if (shadow_we) shadow[cmd_idx] <= cmd_code;
        end
    end
endmodule

// File: tb/tb_tile_update_scheduler.sv
// Bench for tile_update_scheduler: a tile map and shadow model predict the
// command list and the frame_done cycle of every pass.
module tb_tile_update_scheduler;
    logic       tb_clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       start_frame = 1'b0;
    logic       force_redraw = 1'b0;
    logic [2:0] obj_code_in;
    logic       cmd_done = 1'b0;
    logic [3:0] x, y, cmd_x, cmd_y;
    logic [2:0] cmd_code;
    logic       cmd_valid, busy, init_cycle, frame_done;

    logic [2:0] map [192];
    int         mshadow [192];
    bit         mpend = 1'b1;
    bit         minit = 1'b1;
    int         n_pass = 0;
    int         n_checks = 0;

    always #5 tb_clk = ~tb_clk;

    assign obj_code_in = map[int'(y) * 16 + int'(x)];

    tile_update_scheduler #(.GRID_W(16), .GRID_H(12), .CODE_W(3), .XY_W(4)) dut (
        .clk(tb_clk), .sync_reset(sync_reset), .start_frame(start_frame),
        .force_redraw(force_redraw), .obj_code_in(obj_code_in), .cmd_done(cmd_done),
        .x(x), .y(y), .cmd_valid(cmd_valid), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_code(cmd_code), .busy(busy), .init_cycle(init_cycle), .frame_done(frame_done)
    );

    // Runs one pass. lead = idle cycles before SCAN when no start is driven here;
    // fixed_delay < 0 picks a random 0..3 cycle cmd_done delay per command.
    task automatic run_pass(input bit do_start, input bit with_force, input int lead,
                            input int fixed_delay, input int extra_start_at);
        int qx[$], qy[$], qc[$];
        int cyc = 0, waits = 0, ncmd = 0, held = 0, delay = 0, n_exp;
        int ex = -1, ey = -1, ec = -1;
        bit seen_done = 1'b0, in_cmd = 1'b0, redraw;
        redraw = mpend | (do_start & with_force);
        mpend = 1'b0;
        for (int t = 0; t < 192; t++) begin
            if (redraw || int'(map[t]) != mshadow[t]) begin
                qx.push_back(t % 16); qy.push_back(t / 16); qc.push_back(int'(map[t]));
            end
        end
        n_exp = qx.size();
        if (do_start) begin
            @(posedge tb_clk); #1;
            start_frame = 1'b1;
            force_redraw = with_force;
        end
        while (!seen_done && cyc < 3000) begin
            @(posedge tb_clk); #1;
            cyc++;
            force_redraw = 1'b0;
            start_frame = (extra_start_at != 0) && (cyc == extra_start_at || cyc == extra_start_at + 10);
            if (cmd_valid) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    held = 0;
                    delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    waits += delay + 1;
                    ncmd++;
                    n_checks++;
                    if (qx.size() == 0) begin
                        ex = -1; ey = -1; ec = -1;
                        $display("FAIL cmd_extra: got (%0d,%0d) code %0d, want no command", cmd_x, cmd_y, cmd_code);
                    end else begin
                        ex = qx.pop_front(); ey = qy.pop_front(); ec = qc.pop_front();
                        if (int'(cmd_x) !== ex || int'(cmd_y) !== ey || int'(cmd_code) !== ec
                            || int'(x) !== ex || int'(y) !== ey)
                            $display("FAIL cmd_fields: got cmd (%0d,%0d) code %0d scan (%0d,%0d), want (%0d,%0d) code %0d",
                                     cmd_x, cmd_y, cmd_code, x, y, ex, ey, ec);
                        else n_pass++;
                    end
                end else begin
                    held++;
                    n_checks++;
                    if (int'(cmd_x) !== ex || int'(cmd_y) !== ey || int'(cmd_code) !== ec
                        || int'(x) !== ex || int'(y) !== ey)
                        $display("FAIL cmd_stable: got cmd (%0d,%0d) code %0d scan (%0d,%0d), want (%0d,%0d) code %0d",
                                 cmd_x, cmd_y, cmd_code, x, y, ex, ey, ec);
                    else n_pass++;
                end
                cmd_done = (held >= delay);
            end else begin
                in_cmd = 1'b0;
                cmd_done = 1'($urandom_range(0, 1));
            end
            if (frame_done) begin
                seen_done = 1'b1;
                n_checks++;
                if (cyc !== lead + 193 + waits)
                    $display("FAIL frame_time: got cycle %0d, want %0d", cyc, lead + 193 + waits);
                else n_pass++;
                n_checks++;
                if (init_cycle !== minit) $display("FAIL init_at_done: got %0b, want %0b", init_cycle, minit);
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen_done) $display("FAIL pass_timeout: got no frame_done in %0d cycles, want one", cyc);
        else n_pass++;
        n_checks++;
        if (ncmd !== n_exp) $display("FAIL cmd_count: got %0d, want %0d", ncmd, n_exp);
        else n_pass++;
        cmd_done = 1'b0;
        start_frame = 1'b0;
        for (int t = 0; t < 192; t++) mshadow[t] = int'(map[t]);
        minit = 1'b0;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        n_checks++;
        if ({x, y, cmd_x, cmd_y, cmd_code} !== 19'd0) $display("FAIL rst_coords: got %h, want 0", {x, y, cmd_x, cmd_y, cmd_code});
        else n_pass++;
        n_checks++;
        if ({cmd_valid, busy, frame_done, init_cycle} !== 4'b0001)
            $display("FAIL rst_flags: got %b, want 0001", {cmd_valid, busy, frame_done, init_cycle});
        else n_pass++;
        for (int t = 0; t < 192; t++) mshadow[t] = 0;
        mpend = 1'b1;
        minit = 1'b1;
        sync_reset = 1'b0;
        run_pass(1'b0, 1'b0, 0, 0, 0);
        @(posedge tb_clk); #1;
        n_checks++;
        if ({init_cycle, frame_done, busy} !== 3'b000)
            $display("FAIL after_init: got %b, want 000", {init_cycle, frame_done, busy});
        else n_pass++;
    endtask

    task automatic test_no_change();
        run_pass(1'b1, 1'b0, 0, -1, 0);
    endtask

    task automatic test_single_change();
        map[4 * 16 + 7] = 3'd3;
        run_pass(1'b1, 1'b0, 0, 5, 0);
    endtask

    task automatic test_double_start();
        repeat (4) map[$urandom_range(0, 191)] = 3'($urandom_range(0, 7));
        run_pass(1'b1, 1'b0, 0, -1, 50);
        run_pass(1'b0, 1'b0, 1, -1, 0);
        for (int c = 0; c < 30; c++) begin
            @(posedge tb_clk); #1;
            cmd_done = 1'($urandom_range(0, 1));
            n_checks++;
            if ({busy, cmd_valid, frame_done} !== 3'b000)
                $display("FAIL idle_quiet: got %b, want 000", {busy, cmd_valid, frame_done});
            else n_pass++;
        end
        cmd_done = 1'b0;
    endtask

    task automatic test_force_redraw();
        @(posedge tb_clk); #1;
        force_redraw = 1'b1;
        @(posedge tb_clk); #1;
        force_redraw = 1'b0;
        mpend = 1'b1;
        run_pass(1'b1, 1'b0, 0, -1, 0);
        run_pass(1'b1, 1'b0, 0, -1, 0);
        run_pass(1'b1, 1'b1, 0, -1, 0);
        run_pass(1'b1, 1'b0, 0, -1, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            int n = int'($urandom_range(1, 10));
            for (int k = 0; k < n; k++) map[$urandom_range(0, 191)] = 3'($urandom_range(0, 7));
            run_pass(1'b1, 1'b0, 0, -1, 0);
        end
    endtask

    task automatic test_reset_in_wait();
        bit found = 1'b0;
        @(posedge tb_clk); #1;
        map[4 * 16 + 4] = map[4 * 16 + 4] + 3'd1;
        start_frame = 1'b1;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge tb_clk); #1;
            start_frame = 1'b0;
            cmd_done = 1'b0;
            if (cmd_valid) found = 1'b1;
        end
        n_checks++;
        if (!found || cmd_x !== 4'd4 || cmd_y !== 4'd4)
            $display("FAIL wait_reach: got found=%0b cmd (%0d,%0d), want (4,4)", found, cmd_x, cmd_y);
        else n_pass++;
        repeat (2) @(posedge tb_clk);
        #1;
        sync_reset = 1'b1;
        cmd_done = 1'b1;
        @(posedge tb_clk); #1;
        n_checks++;
        if ({cmd_valid, x, y, init_cycle, busy} !== {1'b0, 4'd0, 4'd0, 1'b1, 1'b0})
            $display("FAIL rst_in_wait: got valid=%0b xy=(%0d,%0d) init=%0b busy=%0b, want 0 (0,0) 1 0",
                     cmd_valid, x, y, init_cycle, busy);
        else n_pass++;
        sync_reset = 1'b0;
        cmd_done = 1'b0;
        for (int t = 0; t < 192; t++) mshadow[t] = 0;
        mpend = 1'b1;
        minit = 1'b1;
        run_pass(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 192; i++) map[i] = 3'($urandom_range(0, 7));
        map[4 * 16 + 7] = 3'd5;
        test_reset();
        test_no_change();
        test_single_change();
        test_double_start();
        test_force_redraw();
        test_random();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
